// File: rtl/pebble_game_if.sv
// Game-core bus: move request from the player side, pit counts and
// winner code back to the display side.
interface pebble_game_if;
    logic       play;
    logic       player_position;
    logic [1:0] winner;
    logic [3:0] pos1;
    logic [3:0] pos2;
    logic [3:0] pos3;
    logic [3:0] pos4;

    // Player/display side drives the move request and watches the board.
    modport master (
        output play,
        output player_position,
        input  winner,
        input  pos1,
        input  pos2,
        input  pos3,
        input  pos4
    );

    // Game core consumes the request and owns the board state.
    modport slave (
        input  play,
        input  player_position,
        output winner,
        output pos1,
        output pos2,
        output pos3,
        output pos4
    );
endinterface

// File: rtl/pebble_game.sv
// Four-pit ring sowing game: the player sows from pit 1 or 2 on a play
// rising edge, the AI answers one cycle later from pit 3 or 4, and the
// core freezes with a winner code once one side runs dry.
module pebble_game (
    input  logic          clock,
    input  logic          reset,
    pebble_game_if.slave  bus
);

    typedef enum logic [1:0] {
        WAIT_PLAYER,
        AI_TURN,
        GAME_OVER
    } state_t;

    // Index 0 is pit 1; ring order follows increasing index, wrapping mod 4.
    typedef logic [3:0][3:0] pits_t;

    state_t     state;
    pits_t      pits;
    logic [1:0] winner;
    logic       play_d;

    logic       play_edge;
    logic [1:0] player_src;
    pits_t      player_pits;
    logic [1:0] player_end;
    logic [1:0] ai_src;
    pits_t      ai_pits;
    logic [1:0] ai_end;

    // Empty the source pit and deal its pebbles round the ring; full laps
    // give every pit (source included) one each, the remainder goes to the
    // pits immediately after the source.
    function automatic pits_t sow(input pits_t p, input logic [1:0] s);
        pits_t      r;
        logic [3:0] n;
        logic [3:0] q;
        logic [1:0] m;
        logic [1:0] idx;
        n = p[s];
        q = {2'b00, n[3:2]};
        m = n[1:0];
        r = p;
        r[s] = '0;
        for (int unsigned d = 1; d <= 4; d++) begin
            idx = s + 2'(d);
            r[idx] = r[idx] + q + ((32'(m) >= d) ? 4'd1 : 4'd0);
        end
        return r;
    endfunction

    // Winner code for a board: player side empty means the player won.
    function automatic logic [1:0] end_code(input pits_t p);
        if (p[0] == '0 && p[1] == '0)
            return 2'b01;
        else if (p[2] == '0 && p[3] == '0)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // Candidate boards for both possible moves, computed from the current board.
    always_comb begin
        play_edge   = bus.play & ~play_d;
        player_src  = {1'b0, bus.player_position};
        player_pits = sow(pits, player_src);
        player_end  = end_code(player_pits);
        ai_src      = (pits[2] >= pits[3] && pits[2] != '0) ? 2'd2 : 2'd3;
        ai_pits     = (pits[ai_src] != '0) ? sow(pits, ai_src) : pits;
        ai_end      = end_code(ai_pits);
    end

    // Turn sequencing, board update and winner register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= WAIT_PLAYER;
            pits   <= {4{4'd2}};
            winner <= '0;
            play_d <= 1'b0;
        end else begin
            play_d <= bus.play;
            case (state)
                WAIT_PLAYER: begin
                    if (play_edge && pits[player_src] != '0) begin
                        pits   <= player_pits;
                        winner <= player_end;
                        state  <= (player_end != 2'b00) ? GAME_OVER : AI_TURN;
                    end
                end
                AI_TURN: begin
                    pits   <= ai_pits;
                    winner <= ai_end;
                    state  <= (ai_end != 2'b00) ? GAME_OVER : WAIT_PLAYER;
                end
                GAME_OVER: begin
                    state <= GAME_OVER;
                end
                default: begin
                    state <= WAIT_PLAYER;
                end
            endcase
        end
    end

    assign bus.pos1   = pits[0];
    assign bus.pos2   = pits[1];
    assign bus.pos3   = pits[2];
    assign bus.pos4   = pits[3];
    assign bus.winner = winner;

endmodule

// File: tb/tb_pebble_game.sv
// Directed bench for pebble_game: each stimulus step queues the board the
// following clock edge must produce; a monitor pops and compares.
module tb_pebble_game;

    logic clock;
    logic reset;

    pebble_game_if bus ();

    pebble_game dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0] p1;
        logic [3:0] p2;
        logic [3:0] p3;
        logic [3:0] p4;
        logic [1:0] w;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_err;
    event chk_now;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Queue the board expected after the next rising edge, driving inputs mid-cycle.
    task automatic step(input logic pl, input logic pp,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d,
                        input logic [1:0] w, input string nm);
        exp_t e;
        @(negedge clock);
        bus.play = pl;
        bus.player_position = pp;
        e.p1 = a; e.p2 = b; e.p3 = c; e.p4 = d; e.w = w; e.nm = nm;
        sb.push_back(e);
    endtask

    // Queue an expectation to be checked right away, without a clock edge.
    task automatic check_now(input string nm);
        exp_t e;
        e.p1 = 4'd2; e.p2 = 4'd2; e.p3 = 4'd2; e.p4 = 4'd2; e.w = 2'b00; e.nm = nm;
        sb.push_back(e);
        ->chk_now;
    endtask

    // Monitor: compare the board after every edge (or immediate request).
    initial begin
        exp_t e;
        int   sum;
        forever begin
            @(posedge clock or chk_now);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (bus.pos1 !== e.p1 || bus.pos2 !== e.p2 || bus.pos3 !== e.p3 ||
                    bus.pos4 !== e.p4 || bus.winner !== e.w) begin
                    n_err++;
                    $display("FAIL %s: got %0d,%0d,%0d,%0d w=%b, want %0d,%0d,%0d,%0d w=%b",
                             e.nm, bus.pos1, bus.pos2, bus.pos3, bus.pos4, bus.winner,
                             e.p1, e.p2, e.p3, e.p4, e.w);
                end
                sum = int'(bus.pos1) + int'(bus.pos2) + int'(bus.pos3) + int'(bus.pos4);
                n_vec++;
                if (sum != 8) begin
                    n_err++;
                    $display("FAIL %s_sum: got %0d, want 8", e.nm, sum);
                end
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.play = 1'b0;
        bus.player_position = 1'b0;
        #2;
        check_now("reset_init");
        @(negedge clock);
        reset = 1'b0;

        // Opening exchange and repeated moves
        step(1, 1, 2, 0, 3, 3, 2'b00, "p_pit2");
        step(1, 1, 3, 1, 0, 4, 2'b00, "ai_pit3_tie");
        step(0, 1, 3, 1, 0, 4, 2'b00, "idle1");
        step(1, 1, 3, 0, 1, 4, 2'b00, "p_pit2_b");
        step(0, 1, 4, 1, 2, 1, 2'b00, "ai_pit4");
        step(1, 0, 1, 2, 3, 2, 2'b00, "p_pit1_lap");
        step(0, 0, 2, 3, 0, 3, 2'b00, "ai_pit3");
        // Held play: one player move, one AI move, then nothing
        step(1, 0, 0, 4, 1, 3, 2'b00, "held_p");
        step(1, 0, 1, 5, 2, 0, 2'b00, "held_ai");
        step(1, 0, 1, 5, 2, 0, 2'b00, "held_3");
        step(1, 1, 1, 5, 2, 0, 2'b00, "held_4");
        step(0, 0, 1, 5, 2, 0, 2'b00, "release");
        step(1, 0, 0, 6, 2, 0, 2'b00, "p_pit1_c");
        step(0, 0, 1, 6, 0, 1, 2'b00, "ai_pit3_c");
        step(1, 0, 0, 7, 0, 1, 2'b00, "p_pit1_d");
        // AI side empties on the AI's own move
        step(0, 0, 1, 7, 0, 0, 2'b10, "ai_wins");
        step(1, 0, 1, 7, 0, 0, 2'b10, "over_press1");
        step(0, 1, 1, 7, 0, 0, 2'b10, "over_idle");
        step(1, 1, 1, 7, 0, 0, 2'b10, "over_press2");
        step(0, 1, 1, 7, 0, 0, 2'b10, "over_idle2");

        // Half-cycle asynchronous reset out of GAME_OVER
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_now("reset_async");
        #2;
        reset = 1'b0;

        step(1, 0, 0, 3, 3, 2, 2'b00, "post_reset_p");
        step(0, 0, 1, 4, 0, 3, 2'b00, "post_reset_ai");
        step(1, 0, 0, 5, 0, 3, 2'b00, "p_e");
        step(0, 0, 1, 6, 1, 0, 2'b00, "ai_e");
        step(1, 0, 0, 7, 1, 0, 2'b00, "p_f");
        step(0, 0, 0, 7, 0, 1, 2'b00, "ai_pit3_one");
        // Illegal: pit 1 is empty
        step(1, 0, 0, 7, 0, 1, 2'b00, "illegal");
        step(0, 0, 0, 7, 0, 1, 2'b00, "illegal_no_ai");
        step(1, 1, 2, 1, 2, 3, 2'b00, "p_pit2_7");
        step(0, 0, 3, 2, 3, 0, 2'b00, "ai_pit4_3");

        repeat (3) @(posedge clock);
        #2;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
